// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: merges the CPU instruction bus (host 0) and data bus (host 1)
// onto one split-transaction memory port. Outstanding reads are tagged in an
// in-order ID FIFO so each read response is steered back to the host that issued it.
module cpu_mem_arbiter #(
   parameter int RESP_FIFO_POW = 3,
   parameter int ADDR_W        = 32,
   parameter int DATA_W        = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,

   input  logic                  instr_req,
   output logic                  instr_ack,
   input  logic                  instr_we,
   input  logic [ADDR_W-1:0]     instr_addr,
   input  logic [DATA_W-1:0]     instr_wdata,
   input  logic [DATA_W/8-1:0]   instr_be,
   output logic                  instr_resp,
   output logic [DATA_W-1:0]     instr_rdata,

   input  logic                  data_req,
   output logic                  data_ack,
   input  logic                  data_we,
   input  logic [ADDR_W-1:0]     data_addr,
   input  logic [DATA_W-1:0]     data_wdata,
   input  logic [DATA_W/8-1:0]   data_be,
   output logic                  data_resp,
   output logic [DATA_W-1:0]     data_rdata,

   output logic                  mem_req,
   input  logic                  mem_ack,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_be,
   input  logic                  mem_resp,
   input  logic [DATA_W-1:0]     mem_rdata,

   output logic                  resp_err_o
);

   localparam int                     DEPTH     = 1 << RESP_FIFO_POW;
   localparam logic [RESP_FIFO_POW:0] DEPTH_CNT = (RESP_FIFO_POW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOCK_I,
      ST_LOCK_D
   } state_t;

   state_t                   state;
   logic                     prio_data;

   logic [DEPTH-1:0]         id_fifo;
   logic [RESP_FIFO_POW-1:0] wr_ptr;
   logic [RESP_FIFO_POW-1:0] rd_ptr;
   logic [RESP_FIFO_POW:0]   count;

   logic                     fifo_full;
   logic                     fifo_empty;
   logic                     instr_ok;
   logic                     data_ok;
   logic                     grant_valid;
   logic                     grant_data;
   logic                     push;
   logic                     pop;
   logic                     head_id;

   assign fifo_full  = (count == DEPTH_CNT);
   assign fifo_empty = (count == '0);
   assign head_id    = id_fifo[rd_ptr];

   // Eligibility: reads wait while every ID slot is taken (registered count,
   // so a pop in the same cycle does not free a slot yet); writes never wait.
   always_comb begin
      instr_ok = instr_req && (instr_we || !fifo_full);
      data_ok  = data_req  && (data_we  || !fifo_full);
   end

   // Grant selection: in IDLE pick a requester by round-robin priority in the
   // same cycle; once locked, the grant holds until the target accepts. Reset
   // forces the grant off so the memory port goes quiet immediately.
   always_comb begin
      grant_valid = 1'b0;
      grant_data  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            grant_valid = instr_ok || data_ok;
            grant_data  = (instr_ok && data_ok) ? prio_data : data_ok;
         end
         ST_LOCK_I: begin
            grant_valid = 1'b1;
            grant_data  = 1'b0;
         end
         ST_LOCK_D: begin
            grant_valid = 1'b1;
            grant_data  = 1'b1;
         end
         default: begin
            grant_valid = 1'b0;
            grant_data  = 1'b0;
         end
      endcase
      if (!rst_i) begin
         grant_valid = 1'b0;
      end
   end

   // Memory port fields follow the granted host; the ack goes only to that host.
   always_comb begin
      mem_req   = grant_valid;
      mem_we    = grant_data ? data_we    : instr_we;
      mem_addr  = grant_data ? data_addr  : instr_addr;
      mem_wdata = grant_data ? data_wdata : instr_wdata;
      mem_be    = grant_data ? data_be    : instr_be;
      instr_ack = grant_valid && !grant_data && mem_ack;
      data_ack  = grant_valid &&  grant_data && mem_ack;
   end

   assign push = grant_valid && mem_ack && !mem_we;
   assign pop  = rst_i && mem_resp && !fifo_empty;

   // Response steering: the FIFO head names the host that owns this response;
   // read data is broadcast and only the strobe is routed.
   always_comb begin
      instr_resp  = pop && !head_id;
      data_resp   = pop &&  head_id;
      instr_rdata = mem_rdata;
      data_rdata  = mem_rdata;
   end

   // Arbitration FSM: a handshake in IDLE stays in IDLE, a stalled grant locks
   // until mem_ack, and every transfer hands priority to the other host.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state     <= ST_IDLE;
         prio_data <= 1'b1;
      end else begin
         if (grant_valid && mem_ack) begin
            prio_data <= !grant_data;
         end
         unique case (state)
            ST_IDLE: begin
               if (grant_valid && !mem_ack) begin
                  state <= grant_data ? ST_LOCK_D : ST_LOCK_I;
               end
            end
            ST_LOCK_I, ST_LOCK_D: begin
               if (mem_ack) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // ID FIFO: push the granted host on every read handshake, pop on every
   // response; a simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         id_fifo <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
      end else begin
         if (push) begin
            id_fifo[wr_ptr] <= grant_data;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky error: a response with nothing outstanding cannot be routed.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         resp_err_o <= 1'b0;
      end else if (mem_resp && fifo_empty) begin
         resp_err_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: directed and randomized stimulus for cpu_mem_arbiter with
// a response scoreboard; the bench also plays the memory target.
module tb_cpu_mem_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LAT = 3;

   logic            clk_i = 1'b0;
   logic            rst_i = 1'b0;
   logic            instr_req = 1'b0, instr_we = 1'b0;
   logic [AW-1:0]   instr_addr = '0;
   logic [DW-1:0]   instr_wdata = '0;
   logic [DW/8-1:0] instr_be = '1;
   logic            instr_ack, instr_resp;
   logic [DW-1:0]   instr_rdata;
   logic            data_req = 1'b0, data_we = 1'b0;
   logic [AW-1:0]   data_addr = '0;
   logic [DW-1:0]   data_wdata = '0;
   logic [DW/8-1:0] data_be = '1;
   logic            data_ack, data_resp;
   logic [DW-1:0]   data_rdata;
   logic            mem_req, mem_we;
   logic            mem_ack = 1'b0;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW/8-1:0] mem_be;
   logic            mem_resp = 1'b0;
   logic [DW-1:0]   mem_rdata = '0;
   logic            resp_err_o;

   typedef struct {
      logic          host;
      logic [DW-1:0] data;
   } exp_t;

   typedef struct {
      logic [AW-1:0] addr;
      int            stamp;
   } pend_t;

   exp_t  exp_q[$];
   pend_t pend_q[$];
   int    checks   = 0;
   int    failures = 0;
   int    cyc      = 0;
   logic  resp_en  = 1'b0;

   always #5 clk_i = ~clk_i;

   cpu_mem_arbiter #(.RESP_FIFO_POW(3), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .instr_req(instr_req), .instr_ack(instr_ack), .instr_we(instr_we),
      .instr_addr(instr_addr), .instr_wdata(instr_wdata), .instr_be(instr_be),
      .instr_resp(instr_resp), .instr_rdata(instr_rdata),
      .data_req(data_req), .data_ack(data_ack), .data_we(data_we),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_be(data_be),
      .data_resp(data_resp), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_ack(mem_ack), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_resp(mem_resp), .mem_rdata(mem_rdata),
      .resp_err_o(resp_err_o)
   );

   // Memory contents as seen by the bench: read data derived from the address.
   function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
      return a ^ 32'hDEAD_BFEF;
   endfunction

   task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock: at negedge record read handshakes for the target and score
   // host responses; after posedge drive the next target response.
   task automatic step_cycle();
      exp_t  e;
      pend_t p;
      @(negedge clk_i);
      if (rst_i && mem_req && mem_ack && !mem_we) begin
         p.addr  = mem_addr;
         p.stamp = cyc;
         pend_q.push_back(p);
      end
      if (instr_resp || data_resp) begin
         if (exp_q.size() == 0) begin
            check_output("resp_unexpected", {62'b0, instr_resp, data_resp}, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check_output("resp_host", {62'b0, instr_resp, data_resp}, e.host ? 64'd1 : 64'd2);
            check_output("resp_rdata", e.host ? data_rdata : instr_rdata, e.data);
         end
      end
      @(posedge clk_i);
      #1;
      cyc++;
      mem_resp  = 1'b0;
      mem_rdata = '0;
      if (resp_en && pend_q.size() > 0 && cyc >= pend_q[0].stamp + LAT) begin
         p         = pend_q.pop_front();
         mem_resp  = 1'b1;
         mem_rdata = mem_model(p.addr);
      end
   endtask

   task automatic apply_stimulus_reset();
      rst_i     = 1'b0;
      instr_req = 1'b0;
      data_req  = 1'b0;
      mem_ack   = 1'b0;
      mem_resp  = 1'b0;
      exp_q.delete();
      pend_q.delete();
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      resp_en = 1'b1;
      while (exp_q.size() > 0 && n < 100) begin
         step_cycle();
         n++;
      end
      check_output(tag, exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      exp_t  e;
      pend_t p;
      logic  prio_m;
      logic  gv, gd;
      int    reads, n;

      // Reset state with both hosts requesting
      instr_req = 1'b1;
      data_req  = 1'b1;
      mem_ack   = 1'b1;
      #3;
      check_output("rst_mem_req", mem_req, 0);
      check_output("rst_acks", {instr_ack, data_ack}, 0);
      check_output("rst_resps", {instr_resp, data_resp}, 0);
      check_output("rst_err", resp_err_o, 0);
      apply_stimulus_reset();
      resp_en = 1'b1;

      // Single read from the instruction bus, zero-latency accept
      instr_req = 1'b1; instr_we = 1'b0; instr_addr = 32'h100; mem_ack = 1'b1;
      #1;
      check_output("single_iack", instr_ack, 1);
      check_output("single_dack", data_ack, 0);
      check_output("single_addr", mem_addr, 32'h100);
      e.host = 1'b0; e.data = 32'hDEADBEEF; exp_q.push_back(e);
      step_cycle();
      instr_req = 1'b0;
      drain("single_drain");

      // Contention: grants alternate data, instr, ... from reset priority
      apply_stimulus_reset();
      resp_en = 1'b1;
      instr_addr = 32'h200; data_addr = 32'h300;
      instr_we = 1'b0; data_we = 1'b0;
      instr_req = 1'b1; data_req = 1'b1; mem_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check_output("cont_dack", data_ack, (i % 2 == 0) ? 1 : 0);
         check_output("cont_iack", instr_ack, (i % 2 == 0) ? 0 : 1);
         e.host = (i % 2 == 0);
         e.data = mem_model(e.host ? data_addr : instr_addr);
         exp_q.push_back(e);
         step_cycle();
         if (e.host) data_addr += 4; else instr_addr += 4;
      end
      instr_req = 1'b0; data_req = 1'b0;
      drain("cont_drain");

      // Grant stability while the target stalls
      mem_ack = 1'b0;
      instr_req = 1'b1; instr_we = 1'b0; instr_addr = 32'h400;
      #1;
      check_output("stab_req", mem_req, 1);
      step_cycle();
      data_req = 1'b1; data_we = 1'b0; data_addr = 32'h500;
      for (int i = 0; i < 5; i++) begin
         #1;
         check_output("stab_addr", mem_addr, 32'h400);
         check_output("stab_dack", data_ack, 0);
         step_cycle();
      end
      mem_ack = 1'b1;
      #1;
      check_output("stab_iack", {instr_ack, data_ack}, 2'b10);
      e.host = 1'b0; e.data = mem_model(32'h400); exp_q.push_back(e);
      step_cycle();
      instr_req = 1'b0;
      #1;
      check_output("stab_dgrant", {instr_ack, data_ack}, 2'b01);
      check_output("stab_daddr", mem_addr, 32'h500);
      e.host = 1'b1; e.data = mem_model(32'h500); exp_q.push_back(e);
      step_cycle();
      data_req = 1'b0;
      drain("stab_drain");

      // FIFO full: eight reads outstanding block a ninth, writes still pass
      apply_stimulus_reset();
      resp_en = 1'b0;
      mem_ack = 1'b1;
      data_req = 1'b1; data_we = 1'b0;
      for (int i = 0; i < 8; i++) begin
         data_addr = 32'h1000 + 32'(4 * i);
         #1;
         check_output("full_fill_ack", data_ack, 1);
         e.host = 1'b1; e.data = mem_model(data_addr); exp_q.push_back(e);
         step_cycle();
      end
      data_addr = 32'h2000;
      #1;
      check_output("full_9th_ack", data_ack, 0);
      check_output("full_9th_req", mem_req, 0);
      step_cycle();
      instr_req = 1'b1; instr_we = 1'b1; instr_addr = 32'h600; instr_wdata = 32'h1234_5678;
      #1;
      check_output("full_wr_ack", {instr_ack, data_ack}, 2'b10);
      check_output("full_wr_we", mem_we, 1);
      step_cycle();
      instr_req = 1'b0; instr_we = 1'b0;
      p = pend_q.pop_front();
      mem_resp = 1'b1; mem_rdata = mem_model(p.addr);
      #1;
      check_output("full_samecyc_pop", data_ack, 0);
      step_cycle();
      #1;
      check_output("full_after_pop", data_ack, 1);
      check_output("full_after_addr", mem_addr, 32'h2000);
      e.host = 1'b1; e.data = mem_model(32'h2000); exp_q.push_back(e);
      step_cycle();
      data_req = 1'b0;
      drain("full_drain");

      // Spurious response and asynchronous reset mid-lock
      apply_stimulus_reset();
      mem_resp = 1'b1; mem_rdata = 32'hBAD0_BAD0;
      #1;
      check_output("spur_resps", {instr_resp, data_resp}, 0);
      step_cycle();
      check_output("spur_err", resp_err_o, 1);
      step_cycle();
      step_cycle();
      check_output("spur_err_sticky", resp_err_o, 1);
      mem_ack = 1'b0;
      instr_req = 1'b1; instr_we = 1'b0; instr_addr = 32'h700;
      step_cycle();
      check_output("lock_req", mem_req, 1);
      #2;
      rst_i = 1'b0;
      #1;
      check_output("arst_mem_req", mem_req, 0);
      check_output("arst_err", resp_err_o, 0);
      apply_stimulus_reset();

      // Randomized traffic against an arbitration model, 20 reads across the FIFO wrap
      resp_en = 1'b1;
      mem_ack = 1'b1;
      prio_m  = 1'b1;
      reads   = 0;
      n       = 0;
      while (reads < 20 && n < 300) begin
         if (!instr_req && $urandom_range(0, 1) == 1) begin
            instr_req = 1'b1; instr_we = ($urandom_range(0, 3) == 0); instr_addr = $urandom;
         end
         if (!data_req && $urandom_range(0, 1) == 1) begin
            data_req = 1'b1; data_we = ($urandom_range(0, 3) == 0); data_addr = $urandom;
         end
         #1;
         gv = instr_req || data_req;
         gd = (instr_req && data_req) ? prio_m : data_req;
         check_output("rr_acks", {instr_ack, data_ack}, {gv && !gd, gv && gd});
         if (gv) begin
            if (!(gd ? data_we : instr_we)) begin
               e.host = gd;
               e.data = mem_model(gd ? data_addr : instr_addr);
               exp_q.push_back(e);
               reads++;
            end
            prio_m = !gd;
         end
         step_cycle();
         if (gv && gd) data_req = 1'b0;
         if (gv && !gd) instr_req = 1'b0;
         n++;
      end
      check_output("rr_reads", reads, 20);
      instr_req = 1'b0; data_req = 1'b0;
      drain("rr_drain");
      check_output("rr_err_clear", resp_err_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
